// File: rtl/alu_top_if.sv
// Operand/opcode capture and result/flag return bundle for alu_top.
// Handshake: the master presents operands and an opcode with dat_ready=1.
// They are captured at that rising edge. ALU_ready=1 after an edge means
// ALU_out and the flags belong to the operation captured at that edge.
// There is no backpressure: the ALU accepts an operation every cycle.
interface alu_top_if;
  logic        dat_ready;
  logic [31:0] ALU_dat1;
  logic [31:0] ALU_dat2;
  logic [4:0]  Instruction_to_ALU;
  logic        ALU_overflow;
  logic        ALU_con_met;
  logic        ALU_zero;
  logic        ALU_err;
  logic        ALU_ready;
  logic [31:0] ALU_out;

  modport master (
    output dat_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU,
    input  ALU_overflow, ALU_con_met, ALU_zero, ALU_err, ALU_ready, ALU_out
  );

  modport slave (
    input  dat_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU,
    output ALU_overflow, ALU_con_met, ALU_zero, ALU_err, ALU_ready, ALU_out
  );
endinterface

// File: rtl/alu_top.sv
// Registered RV32I execute-stage ALU.
// Arithmetic, logic, shift, set-less-than and branch comparisons are
// evaluated combinationally from the bus inputs. The result and flags are
// registered on each edge where dat_ready is high.
module alu_top (
  input  logic       soc_clk,
  input  logic       reset,
  alu_top_if.slave   bus
);

  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;
  logic [31:0] nxt_out;
  logic        nxt_ovf;
  logic        nxt_con;
  logic        nxt_zero;
  logic        nxt_err;

  assign a     = bus.ALU_dat1;
  assign b     = bus.ALU_dat2;
  assign shamt = bus.ALU_dat2[4:0];

  // Evaluate the opcode. Any flag an op does not use stays 0.
  always_comb begin
    nxt_out  = 32'd0;
    nxt_ovf  = 1'b0;
    nxt_con  = 1'b0;
    nxt_zero = 1'b0;
    nxt_err  = 1'b0;
    case (bus.Instruction_to_ALU)
      5'd0:  nxt_con = (a == b);
      5'd1:  nxt_con = (a != b);
      5'd2:  nxt_con = ($signed(a) <  $signed(b));
      5'd3:  nxt_con = ($signed(a) >= $signed(b));
      5'd4:  nxt_con = (a <  b);
      5'd5:  nxt_con = (a >= b);
      5'd6: begin
        nxt_out  = a + b;
        nxt_ovf  = (a[31] == b[31]) && (nxt_out[31] != a[31]);
        nxt_zero = (nxt_out == 32'd0);
      end
      5'd7: begin
        nxt_out  = a - b;
        nxt_ovf  = (a[31] != b[31]) && (nxt_out[31] != a[31]);
        nxt_zero = (nxt_out == 32'd0);
      end
      5'd8:  nxt_out = a << shamt;
      5'd9: begin
        nxt_con = ($signed(a) < $signed(b));
        nxt_out = {31'd0, nxt_con};
      end
      5'd10: begin
        nxt_con = (a < b);
        nxt_out = {31'd0, nxt_con};
      end
      5'd11: nxt_out = a ^ b;
      5'd12: nxt_out = a >> shamt;
      5'd13: nxt_out = 32'($signed(a) >>> shamt);
      5'd14: nxt_out = a | b;
      5'd15: nxt_out = a & b;
      default: nxt_err = 1'b1;
    endcase
  end

  // Capture on dat_ready. Results hold when it is low, and reset clears everything.
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      bus.ALU_out      <= 32'd0;
      bus.ALU_overflow <= 1'b0;
      bus.ALU_con_met  <= 1'b0;
      bus.ALU_zero     <= 1'b0;
      bus.ALU_err      <= 1'b0;
      bus.ALU_ready    <= 1'b0;
    end else if (bus.dat_ready) begin
      bus.ALU_out      <= nxt_out;
      bus.ALU_overflow <= nxt_ovf;
      bus.ALU_con_met  <= nxt_con;
      bus.ALU_zero     <= nxt_zero;
      bus.ALU_err      <= nxt_err;
      bus.ALU_ready    <= 1'b1;
    end else begin
      bus.ALU_ready    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Testbench for alu_top: directed test-plan steps followed by random
// operations, all checked against a behavioural reference model.
module tb_alu_top;

  typedef struct {
    logic [31:0] out;
    logic        ovf;
    logic        con;
    logic        zero;
    logic        err;
    logic        ready;
  } res_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  res_t last;
  logic [31:0] exp_q[$];

  alu_top_if bus();

  alu_top dut (
    .soc_clk (clk),
    .reset   (reset),
    .bus     (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, written from the opcode rules using wide signed arithmetic.
  function automatic res_t model(input int op, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    longint sa;
    longint sb;
    longint s;
    int     sh;
    r = '{out: 32'd0, ovf: 1'b0, con: 1'b0, zero: 1'b0, err: 1'b0, ready: 1'b1};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      0: r.con = (a == b);
      1: r.con = (a != b);
      2: r.con = (sa < sb);
      3: r.con = (sa >= sb);
      4: r.con = ({32'd0, a} < {32'd0, b});
      5: r.con = ({32'd0, a} >= {32'd0, b});
      6, 7: begin
        s = (op == 6) ? sa + sb : sa - sb;
        r.out  = s[31:0];
        r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.zero = (r.out == 32'd0);
      end
      8:  begin r.out = a; repeat (sh) r.out = {r.out[30:0], 1'b0}; end
      9:  begin r.con = (sa < sb); r.out = {31'd0, r.con}; end
      10: begin r.con = (a < b);   r.out = {31'd0, r.con}; end
      11: r.out = a ^ b;
      12: begin r.out = a; repeat (sh) r.out = {1'b0, r.out[31:1]}; end
      13: begin r.out = a; repeat (sh) r.out = {r.out[31], r.out[31:1]}; end
      14: r.out = a | b;
      15: r.out = a & b;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag, input res_t e);
    check({tag, ".out"},   bus.ALU_out, e.out);
    check({tag, ".ovf"},   {31'd0, bus.ALU_overflow}, {31'd0, e.ovf});
    check({tag, ".con"},   {31'd0, bus.ALU_con_met},  {31'd0, e.con});
    check({tag, ".zero"},  {31'd0, bus.ALU_zero},     {31'd0, e.zero});
    check({tag, ".err"},   {31'd0, bus.ALU_err},      {31'd0, e.err});
    check({tag, ".ready"}, {31'd0, bus.ALU_ready},    {31'd0, e.ready});
  endtask

  // Driver: present one operation at negedge, check #1 after the capture edge
  task automatic do_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.dat_ready          = 1'b1;
    bus.Instruction_to_ALU = 5'(op);
    bus.ALU_dat1           = a;
    bus.ALU_dat2           = b;
    last = model(op, a, b);
    exp_q.push_back(last.out);
    @(posedge clk);
    #1;
    check_all(tag, last);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    bus.dat_ready = 1'b0;
    bus.ALU_dat1  = $urandom;
    @(posedge clk);
    #1;
    last.ready = 1'b0;
    check_all(tag, last);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    reset = 1'b1;
    bus.dat_ready          = 1'b1;
    bus.Instruction_to_ALU = 5'd6;
    bus.ALU_dat1           = 32'd1;
    bus.ALU_dat2           = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    last = '{out: 32'd0, ovf: 1'b0, con: 1'b0, zero: 1'b0, err: 1'b0, ready: 1'b0};
    check_all("reset", last);
    @(negedge clk);
    reset = 1'b0;
    bus.dat_ready = 1'b0;

    // Test-plan steps, with literal expected values alongside the model
    do_op("add", 6, 32'd5, 32'd3);
    check("add.k", bus.ALU_out, 32'h8);
    do_op("add_ovf", 6, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf.k", {bus.ALU_out[31:0]}, 32'h8000_0000);
    check("add_ovf.kf", {31'd0, bus.ALU_overflow}, 32'd1);
    do_op("sub_zero", 7, 32'd5, 32'd5);
    check("sub_zero.k", {31'd0, bus.ALU_zero}, 32'd1);
    do_op("sll", 8, 32'd3, 32'd2);
    check("sll.k", bus.ALU_out, 32'hC);
    do_op("srl", 12, 32'hF000_0000, 32'd4);
    check("srl.k", bus.ALU_out, 32'h0F00_0000);
    do_op("sra", 13, 32'hF000_0000, 32'd4);
    check("sra.k", bus.ALU_out, 32'hFF00_0000);
    do_op("sll_b5", 8, 32'd1, 32'h21);
    check("sll_b5.k", bus.ALU_out, 32'h2);
    do_op("slt", 9, 32'd3, 32'd5);
    check("slt.k", bus.ALU_out, 32'd1);
    do_op("sltu", 10, 32'hFFFF_FFFF, 32'd1);
    check("sltu.k", {31'd0, bus.ALU_con_met}, 32'd0);
    do_op("xor", 11, 32'h0F0F_0F0F, 32'hFF00_FF00);
    check("xor.k", bus.ALU_out, 32'hF00F_F00F);
    do_op("or", 14, 32'h0F0F_0F0F, 32'hFF00_FF00);
    check("or.k", bus.ALU_out, 32'hFF0F_FF0F);
    do_op("and", 15, 32'h0F0F_0F0F, 32'hFF00_FF00);
    check("and.k", bus.ALU_out, 32'h0F00_0F00);
    do_op("beq", 0, 32'd5, 32'd5);
    check("beq.k", {31'd0, bus.ALU_con_met}, 32'd1);
    do_op("bne", 1, 32'd5, 32'd3);
    check("bne.k", {31'd0, bus.ALU_con_met}, 32'd1);
    do_op("blt", 2, 32'hFFFF_FFFD, 32'd0);
    check("blt.k", {31'd0, bus.ALU_con_met}, 32'd1);
    do_op("bge", 3, 32'd0, 32'hFFFF_FFFD);
    check("bge.k", {31'd0, bus.ALU_con_met}, 32'd1);
    do_op("bltu", 4, 32'd3, 32'd5);
    do_op("bgeu", 5, 32'd5, 32'd3);
    do_op("bltu_neg", 4, 32'hFFFF_FFFD, 32'd0);
    check("bltu_neg.k", {31'd0, bus.ALU_con_met}, 32'd0);
    do_op("bad_op", 16, 32'd7, 32'd9);
    check("bad_op.k", {31'd0, bus.ALU_err}, 32'd1);

    // Held results while dat_ready is low, then a repeat of an identical operation
    do_op("pre_hold", 6, 32'h1234_0000, 32'h0000_5678);
    idle_cycle("hold1");
    idle_cycle("hold2");
    check("hold.k", bus.ALU_out, 32'h1234_5678);
    do_op("same1", 7, 32'd1, 32'd2);
    do_op("same2", 7, 32'd1, 32'd2);

    // Reset mid-stream overrides a capture on the same edge
    @(negedge clk);
    reset = 1'b1;
    bus.dat_ready = 1'b1;
    bus.Instruction_to_ALU = 5'd6;
    bus.ALU_dat1 = 32'd10;
    bus.ALU_dat2 = 32'd20;
    @(posedge clk);
    #1;
    last = '{out: 32'd0, ovf: 1'b0, con: 1'b0, zero: 1'b0, err: 1'b0, ready: 1'b0};
    check_all("mid_reset", last);
    @(negedge clk);
    reset = 1'b0;
    bus.dat_ready = 1'b0;

    // Random back-to-back operations with occasional idle cycles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) idle_cycle("rand_idle");
      else do_op("rand", int'($urandom_range(0, 31)), rand_operand(), rand_operand());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
